feature_collector: RTL
======================

Name: feature_collector

Overview:
- Sits directly downstream of the BRIEF descriptor stage. Captures each valid keypoint record (coordinates, 256-bit descriptor, score, depth) on its one-cycle flag pulse.
- Buffers records in an on-chip FIFO and hands them to the matcher/DRAM writer over a valid/ready stream.
- Frames features: enforces a per-frame cap, counts drops, and pulses a done strobe once a frame is fully drained.

Parameters:
- DEPTH, 32, FIFO entries; power of two, ≥2.
- MAX_FEAT, 500, maximum features accepted per frame.
- SCORE_TH, 8'd20, minimum score accepted; used only with FEATURE_SCORE_TH_EN.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset, asynchronous, active-high
- i_frame_start  in  1  one-cycle pulse, start of frame
- i_frame_end  in  1  one-cycle pulse, last BRIEF output of frame has been issued
- i_flag  in  1  record valid from BRIEF stage (single-cycle)
- i_coor_x  in  10  keypoint x
- i_coor_y  in  10  keypoint y
- i_descriptor  in  256  BRIEF bit string
- i_score  in  8  corner score
- i_depth  in  16  depth sample
- o_valid  out  1  output record valid
- i_ready  in  1  consumer accepts record
- o_coor_x  out  10  stored x
- o_coor_y  out  10  stored y
- o_descriptor  out  256  stored descriptor
- o_score  out  8  stored score
- o_depth  out  16  stored depth
- o_feat_cnt  out  10  features accepted this frame
- o_drop_cnt  out  10  features dropped this frame (saturating at 1023)
- o_full  out  1  FIFO full
- o_frame_done  out  1  one-cycle pulse: frame collected and drained

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: every output 0, FIFO empty, state IDLE.
- State IDLE:
  - i_flag ignored, not counted.
  - i_frame_start → COLLECT; clears o_feat_cnt and o_drop_cnt.
- State COLLECT: a record is accepted when i_flag=1 && !o_full && o_feat_cnt<MAX_FEAT.
  - Accept: write to FIFO; o_feat_cnt+1.
  - Reject: o_drop_cnt+1 (saturating). This includes full FIFO and cap reached.
  - i_frame_end → DRAIN. A flag in the same cycle as i_frame_end is still processed.
- State DRAIN:
  - i_flag ignored and not counted.
  - When the FIFO is empty and no record is in flight: assert o_frame_done for one cycle → IDLE.
  - If the FIFO is already empty on entry, the pulse comes on the first DRAIN cycle.
- i_frame_start in COLLECT or DRAIN:
  - Restarts COLLECT and clears both counters.
  - FIFO contents are kept.
  - No o_frame_done for the aborted frame.
  - A flag in the same cycle counts as the first record of the new frame (cnt=1).
- Output timing and handshake:
  - First-word-fall-through, registered.
  - A record written at clock edge N is presented with o_valid=1 after edge N+1.
  - Pop on o_valid && i_ready.
  - Output fields are held stable while o_valid && !i_ready.
  - Output fields are zero when o_valid=0.
- Full FIFO:
  - o_full is registered. A write is refused when full, even if a pop occurs in the same cycle (no pass-through).
  - Pop and push in the same cycle when neither full nor empty: occupancy unchanged.
- Pointers: log2(DEPTH)+1 bits wide, wrap naturally. Full when MSBs differ and the rest are equal.
- Counters: o_feat_cnt never exceeds MAX_FEAT; o_drop_cnt saturates at 1023.
- Reset mid-frame: FIFO flushed, counters cleared, state IDLE; any in-progress output is lost.

Optional Feature:
- Macro: FEATURE_SCORE_TH_EN.
- Defined: in COLLECT, a flag with i_score < SCORE_TH is discarded silently. It is not written and not counted in o_drop_cnt or o_feat_cnt.
- Undefined: no score filtering; SCORE_TH is unused.

Decomposition:
- Package feature_pkg:
  - typedef feat_rec_t: packed struct {coor_x[9:0], coor_y[9:0], descriptor[255:0], score[7:0], depth[15:0]}, 300 bits.
  - Width constants COOR_W=10, DESC_W=256, SCORE_W=8, DEPTH_W=16, CNT_W=10.
  - State enum {IDLE, COLLECT, DRAIN}.
- Sub-module feat_fifo: parameterised synchronous FWFT FIFO of feat_rec_t.
  - Ports: push, pop, full, empty, data in/out.
  - Top level holds the FSM, accept logic and counters.

Test Plan:
- Reset, frame_start, 3 flags (x=5,10,15) with i_ready=1 → o_valid one cycle after each write, records emitted in order, o_feat_cnt=3; frame_end → o_frame_done pulse after the last pop.
- i_ready=0, 34 flags with DEPTH=32 → o_full after 32nd, o_drop_cnt=2; release ready → exactly 32 records out, FIFO order preserved.
- MAX_FEAT=4, 6 flags with ready=1 → o_feat_cnt=4, o_drop_cnt=2, only the first 4 emitted.
- Flags in IDLE and in DRAIN → no writes, counters unchanged; flag coincident with frame_end → accepted.
- i_frame_start in the same cycle as a flag mid-frame → counters cleared then o_feat_cnt=1, old FIFO entries still emitted, no o_frame_done for the old frame.
- With FEATURE_SCORE_TH_EN and SCORE_TH=20: flags with score 19, 20, 255 → only 20 and 255 stored, o_drop_cnt=0; async i_rst asserted mid-drain → all outputs 0 immediately.

Source files
------------

// File: rtl/feature_pkg.sv
// Shared types and widths for the feature collector: the keypoint record layout
// and the framing state encoding.
package feature_pkg;

    localparam int COOR_W  = 10;
    localparam int DESC_W  = 256;
    localparam int SCORE_W = 8;
    localparam int DEPTH_W = 16;
    localparam int CNT_W   = 10;

    typedef struct packed {
        logic [COOR_W-1:0]  coor_x;
        logic [COOR_W-1:0]  coor_y;
        logic [DESC_W-1:0]  descriptor;
        logic [SCORE_W-1:0] score;
        logic [DEPTH_W-1:0] depth;
    } feat_rec_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_t;

endpackage

// File: rtl/feat_fifo.sv
// First-word-fall-through FIFO of keypoint records with a registered output stage.
// Storage is a plain array so it maps onto block RAM; the output register is the RAM read.
module feat_fifo
    import feature_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  feat_rec_t din,
    output logic      full,
    output logic      empty,
    output logic      valid,
    output feat_rec_t dout
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    feat_rec_t      mem [DEPTH];
    feat_rec_t      data_reg;
    logic [PW-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]  rd_ptr_reg, rd_ptr_next;
    logic           valid_reg;
    logic           full_reg;
    logic           do_push;
    logic           do_pop;

    assign do_push     = push && !full_reg;
    assign do_pop      = pop && valid_reg;
    assign wr_ptr_next = wr_ptr_reg + PW'(do_push);
    assign rd_ptr_next = rd_ptr_reg + PW'(do_pop);

    // The head entry stays in RAM until popped, so the output register never adds capacity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
        data_reg <= mem[rd_ptr_next[AW-1:0]];
    end

    // Validity uses the pre-write pointer: an entry becomes visible one edge after its write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            valid_reg  <= 1'b0;
            full_reg   <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            valid_reg  <= (wr_ptr_reg != rd_ptr_next);
            full_reg   <= (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                          (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
        end
    end

    assign full  = full_reg;
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign valid = valid_reg;
    assign dout  = valid_reg ? data_reg : '0;

endmodule

// File: rtl/feature_collector.sv
// Collects BRIEF keypoint records per frame into a FIFO, with a per-frame cap,
// drop counting and a frame-drained strobe. Optional score gate: FEATURE_SCORE_TH_EN.
module feature_collector
    import feature_pkg::*;
#(
    parameter int          DEPTH    = 32,
    parameter int          MAX_FEAT = 500,
    parameter logic [7:0]  SCORE_TH = 8'd20
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_frame_start,
    input  logic               i_frame_end,
    input  logic               i_flag,
    input  logic [COOR_W-1:0]  i_coor_x,
    input  logic [COOR_W-1:0]  i_coor_y,
    input  logic [DESC_W-1:0]  i_descriptor,
    input  logic [SCORE_W-1:0] i_score,
    input  logic [DEPTH_W-1:0] i_depth,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [COOR_W-1:0]  o_coor_x,
    output logic [COOR_W-1:0]  o_coor_y,
    output logic [DESC_W-1:0]  o_descriptor,
    output logic [SCORE_W-1:0] o_score,
    output logic [DEPTH_W-1:0] o_depth,
    output logic [CNT_W-1:0]   o_feat_cnt,
    output logic [CNT_W-1:0]   o_drop_cnt,
    output logic               o_full,
    output logic               o_frame_done
);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] feat_cnt_reg, feat_cnt_next;
    logic [CNT_W-1:0] drop_cnt_reg, drop_cnt_next;
    logic             fifo_full, fifo_empty, fifo_valid;
    feat_rec_t        rec_in, rec_out;
    logic             score_ok, collecting, under_cap, accept, reject;

`ifdef FEATURE_SCORE_TH_EN
    assign score_ok = (i_score >= SCORE_TH);
`else
    logic unused_score_th;
    assign unused_score_th = ^SCORE_TH;
    assign score_ok        = 1'b1;
`endif

    // A frame start opens a fresh frame in the same cycle, so its flag sees a cleared count.
    assign collecting = i_frame_start || (state_reg == COLLECT);
    assign under_cap  = i_frame_start || (feat_cnt_reg < CNT_W'(MAX_FEAT));
    assign accept     = i_flag && score_ok && collecting && !fifo_full && under_cap;
    assign reject     = i_flag && score_ok && collecting && !accept;

    assign rec_in = '{coor_x: i_coor_x, coor_y: i_coor_y, descriptor: i_descriptor,
                      score: i_score, depth: i_depth};

    feat_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (accept),
        .pop   (i_ready),
        .din   (rec_in),
        .full  (fifo_full),
        .empty (fifo_empty),
        .valid (fifo_valid),
        .dout  (rec_out)
    );

    always_comb begin
        state_next    = state_reg;
        feat_cnt_next = i_frame_start ? '0 : feat_cnt_reg;
        drop_cnt_next = i_frame_start ? '0 : drop_cnt_reg;
        if (accept) begin
            feat_cnt_next = feat_cnt_next + 1'b1;
        end
        if (reject && (drop_cnt_next != '1)) begin
            drop_cnt_next = drop_cnt_next + 1'b1;
        end
        if (i_frame_start) begin
            state_next = COLLECT;
        end else begin
            case (state_reg)
                COLLECT: if (i_frame_end) state_next = DRAIN;
                DRAIN:   if (fifo_empty)  state_next = IDLE;
                default: state_next = state_reg;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg    <= IDLE;
            feat_cnt_reg <= '0;
            drop_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            feat_cnt_reg <= feat_cnt_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    // Empty pointers already cover the output stage, so empty means nothing is left in flight.
    assign o_frame_done = (state_reg == DRAIN) && fifo_empty && !i_frame_start;
    assign o_valid      = fifo_valid;
    assign o_coor_x     = rec_out.coor_x;
    assign o_coor_y     = rec_out.coor_y;
    assign o_descriptor = rec_out.descriptor;
    assign o_score      = rec_out.score;
    assign o_depth      = rec_out.depth;
    assign o_feat_cnt   = feat_cnt_reg;
    assign o_drop_cnt   = drop_cnt_reg;
    assign o_full       = fifo_full;

endmodule
